// File: rtl/seq_priority_encoder.sv
// seq_priority_encoder
//   Accepts an N-bit request vector over a valid/ready handshake, holds it in a
//   pending register and emits the index of every set bit as a stream of beats,
//   one per accepted output transfer, in priority order. MSB_FIRST selects whether
//   the highest or the lowest set index is served first. An all-zero vector is
//   accepted and discarded, and that is flagged with a one-cycle zero_drop pulse.
//
//   Every output comes straight from a flop. The next index and last flag are
//   precomputed from the next pending value, so neither in_vec nor out_ready has
//   a combinational path to any output.

module seq_priority_encoder #(
    parameter int N         = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N-1:0]         in_vec,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [$clog2(N)-1:0] out_idx,
    output logic                 out_last,
    output logic                 zero_drop
);

    localparam int W = $clog2(N);

    localparam logic [N-1:0] ZERO_V = {N{1'b0}};
    localparam logic [N-1:0] ONE_V  = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    // Index of the bit that is served first. Every bit is scanned, so the
    // result is always below N, even when N is not a power of two.
    function automatic logic [W-1:0] prio_idx(input logic [N-1:0] v);
        logic [W-1:0] idx_v;
        idx_v = {W{1'b0}};
        if (MSB_FIRST) begin
            // Ascending scan: the last set bit found (the highest) wins.
            for (int i = 0; i < N; i++) begin
                idx_v = v[i] ? W'(i) : idx_v;
            end
        end else begin
            // Descending scan: the last set bit found (the lowest) wins.
            for (int i = N - 1; i >= 0; i--) begin
                idx_v = v[i] ? W'(i) : idx_v;
            end
        end
        return idx_v;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic single_bit(input logic [N-1:0] v);
        return (v != ZERO_V) && ((v & (v - ONE_V)) == ZERO_V);
    endfunction

    state_t         state_r;
    state_t         state_nxt_s;
    logic [N-1:0]   pend_r;
    logic [N-1:0]   pend_nxt_s;
    logic [N-1:0]   clr_mask_s;
    logic [W-1:0]   out_idx_r;
    logic           out_last_r;
    logic           out_valid_r;
    logic           zero_drop_r;
    logic           zero_drop_nxt_s;

    // One-hot mask for the bit being served in the current beat.
    always_comb begin
        clr_mask_s = ONE_V << out_idx_r;
    end

    // Next-state, next-pending and zero-drop decode.
    always_comb begin
        state_nxt_s     = state_r;
        pend_nxt_s      = pend_r;
        zero_drop_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    if (in_vec != ZERO_V) begin
                        pend_nxt_s  = in_vec;
                        state_nxt_s = SCAN;
                    end else begin
                        zero_drop_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SCAN: begin
                if (out_ready) begin
                    pend_nxt_s = pend_r & ~clr_mask_s;
                    if (out_last_r) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = SCAN;
                    end
                end else begin
                    pend_nxt_s = pend_r;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                pend_nxt_s  = ZERO_V;
            end
        endcase
    end

    // State, pending vector and registered outputs; reset wins over any transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            pend_r      <= ZERO_V;
            out_valid_r <= 1'b0;
            out_idx_r   <= {W{1'b0}};
            out_last_r  <= 1'b0;
            zero_drop_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pend_r      <= pend_nxt_s;
            out_valid_r <= (state_nxt_s == SCAN);
            out_idx_r   <= prio_idx(pend_nxt_s);
            out_last_r  <= single_bit(pend_nxt_s);
            zero_drop_r <= zero_drop_nxt_s;
        end
    end

    // Port drive; in_ready is decoded from the state register alone.
    always_comb begin
        in_ready  = (state_r == IDLE);
        out_valid = out_valid_r;
        out_idx   = out_idx_r;
        out_last  = out_last_r;
        zero_drop = zero_drop_r;
    end

endmodule

// File: tb/tb_seq_priority_encoder.sv
// Self-checking bench for seq_priority_encoder. Two instances with N=8 share all
// inputs: one serves the highest index first, the other the lowest first.
// Expected beats are pushed to a per-instance queue when a vector is driven and
// popped when the instance shows a beat that is accepted.

module tb_seq_priority_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       in_ready_m, out_valid_m, out_last_m, zero_drop_m;
    logic [2:0] out_idx_m;
    logic       in_ready_l, out_valid_l, out_last_l, zero_drop_l;
    logic [2:0] out_idx_l;

    int tests_run = 0;
    int tests_failed = 0;

    // {last, idx}
    logic [3:0] q_m[$];
    logic [3:0] q_l[$];

    seq_priority_encoder #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_vec(in_vec), .out_valid(out_valid_m), .out_ready(out_ready),
        .out_idx(out_idx_m), .out_last(out_last_m), .zero_drop(zero_drop_m)
    );

    seq_priority_encoder #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_vec(in_vec), .out_valid(out_valid_l), .out_ready(out_ready),
        .out_idx(out_idx_l), .out_last(out_last_l), .zero_drop(zero_drop_l)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: beats in priority order, last flag on the final one.
    task automatic push_exp(input logic [7:0] v);
        int n;
        int k;
        n = $countones(v);
        k = 0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) begin
                k++;
                q_m.push_back({(k == n), 3'(i)});
            end
        end
        k = 0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                k++;
                q_l.push_back({(k == n), 3'(i)});
            end
        end
    endtask

    // Scoreboard for the MSB-first instance.
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst && out_valid_m && out_ready) begin
            if (q_m.size() == 0) begin
                check("msb_unexpected_beat", 32'(out_idx_m), 32'd99);
            end else begin
                e = q_m.pop_front();
                check("msb_idx", 32'(out_idx_m), 32'(e[2:0]));
                check("msb_last", 32'(out_last_m), 32'(e[3]));
            end
        end
    end

    // Scoreboard for the LSB-first instance.
    always @(negedge clk) begin
        logic [3:0] e;
        if (!rst && out_valid_l && out_ready) begin
            if (q_l.size() == 0) begin
                check("lsb_unexpected_beat", 32'(out_idx_l), 32'd99);
            end else begin
                e = q_l.pop_front();
                check("lsb_idx", 32'(out_idx_l), 32'(e[2:0]));
                check("lsb_last", 32'(out_last_l), 32'(e[3]));
            end
        end
    end

    task automatic send(input logic [7:0] v);
        int t;
        t = 0;
        while (!(in_ready_m && in_ready_l) && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'(t), 32'd0);
        in_valid = 1'b1;
        in_vec   = v;
        push_exp(v);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait until all expected beats are seen; optionally jitter out_ready.
    task automatic drain(input bit jitter);
        int t;
        t = 0;
        while ((q_m.size() != 0 || q_l.size() != 0) && t < 200) begin
            @(posedge clk); #1;
            out_ready = jitter ? 1'($urandom_range(0, 1)) : 1'b1;
            t++;
        end
        if (t >= 200) check("drain_timeout", 32'(q_m.size() + q_l.size()), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        int cnt;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b1;

        // 1. reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid_m), 32'd0);
        check("rst_out_idx", 32'(out_idx_m), 32'd0);
        check("rst_out_last", 32'(out_last_m), 32'd0);
        check("rst_zero_drop", 32'(zero_drop_m), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready_m), 32'd1);
        check("rst_out_valid_after", 32'(out_valid_l), 32'd0);

        // 2. one-hot vectors
        for (int i = 0; i < 8; i++) begin
            send(8'h01 << i);
            drain(1'b0);
        end

        // 3. multi-bit vector, one beat per cycle, in_ready low for three cycles
        send(8'b1010_0100);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (in_ready_m) break;
            cnt++;
        end
        check("busy_cycles", 32'(cnt), 32'd3);
        drain(1'b0);

        // 4. stall holds the first beat stable
        out_ready = 1'b0;
        send(8'b1010_0100);
        repeat (4) begin
            @(negedge clk);
            check("stall_valid", 32'(out_valid_m), 32'd1);
            check("stall_idx_msb", 32'(out_idx_m), 32'd7);
            check("stall_idx_lsb", 32'(out_idx_l), 32'd2);
            check("stall_last", 32'(out_last_m), 32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drain(1'b0);

        // 5. all-zero vector is dropped with a single-cycle pulse
        send(8'h00);
        @(negedge clk);
        check("zd_pulse", 32'(zero_drop_m), 32'd1);
        check("zd_out_valid", 32'(out_valid_m), 32'd0);
        check("zd_in_ready", 32'(in_ready_m), 32'd1);
        @(negedge clk);
        check("zd_pulse_end", 32'(zero_drop_l), 32'd0);
        check("zd_out_valid2", 32'(out_valid_l), 32'd0);
        @(posedge clk); #1;

        // 6. reset mid-scan discards the rest, then a fresh vector
        send(8'hFF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        q_m.delete();
        q_l.delete();
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid_m), 32'd0);
        check("midrst_in_ready", 32'(in_ready_m), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(8'b0000_0011);
        drain(1'b0);

        // Random vectors with a jittering consumer.
        for (int i = 0; i < 20; i++) begin
            out_ready = 1'($urandom_range(0, 1));
            send(8'($urandom_range(1, 255)));
            drain(1'b1);
        end

        check("final_queues_empty", 32'(q_m.size() + q_l.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
